// File: rtl/omsp_permute_pkg.sv
// Shared constants for the omsp_permute peripheral: register map, bit positions, modes and states.
// Optional feature macro: PERMUTE_BITREV_EN (bit-reverse mode and its STAT[15] capability flag).
package omsp_permute_pkg;

    localparam logic [1:0] OFS_CTRL = 2'd0;
    localparam logic [1:0] OFS_STAT = 2'd1;
    localparam logic [1:0] OFS_DIN  = 2'd2;
    localparam logic [1:0] OFS_DOUT = 2'd3;

    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_MODE_MSB = 1;
    localparam int CTRL_START    = 2;
    localparam int CTRL_IE       = 3;
    localparam int CTRL_CLR      = 4;

    localparam int STAT_FULL  = 0;
    localparam int STAT_BUSY  = 1;
    localparam int STAT_DONE  = 2;
    localparam int STAT_DRAIN = 3;
    localparam int STAT_OVF   = 4;
    localparam int STAT_CAP   = 15;

    typedef enum logic [1:0] {
        MODE_IDENT  = 2'd0,
        MODE_TRANS  = 2'd1,
        MODE_BITREV = 2'd2,
        MODE_IDENT3 = 2'd3
    } perm_mode_e;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FULL  = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DRAIN = 2'd3
    } perm_state_e;

`ifdef PERMUTE_BITREV_EN
    localparam logic BITREV_CAP = 1'b1;
`else
    localparam logic BITREV_CAP = 1'b0;
`endif

endpackage

// File: rtl/omsp_permute_if.sv
// openMSP430 peripheral bus bundle; the CPU side is the master, the peripheral the slave.
interface omsp_permute_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (output per_addr, per_din, per_en, per_we, input per_dout);
    modport slave  (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/omsp_permute_index.sv
// Combinational source-index map for the copy phase: identity, transpose or bit-reverse of k.
// Bit-reverse exists only when PERMUTE_BITREV_EN is defined; otherwise mode 2 maps like identity.
module omsp_permute_index
    import omsp_permute_pkg::*;
#(
    parameter int DIM_LOG2 = 2
) (
    input  perm_mode_e              mode,
    input  logic [2*DIM_LOG2-1:0]   k,
    output logic [2*DIM_LOG2-1:0]   src
);
    localparam int AW = 2 * DIM_LOG2;

    // Select the source index for the word being written at position k
    always_comb begin
        src = k;
        case (mode)
            MODE_TRANS: src = {k[DIM_LOG2-1:0], k[AW-1:DIM_LOG2]};
`ifdef PERMUTE_BITREV_EN
            MODE_BITREV: begin
                for (int i = 0; i < AW; i++) begin
                    src[i] = k[AW-1-i];
                end
            end
`endif
            default: src = k;
        endcase
    end
endmodule

// File: rtl/omsp_permute.sv
// openMSP430 permutation peripheral: stream DEPTH words in, copy them through an index map, stream out.
// Bit-reverse mode and the STAT[15] capability flag exist only when PERMUTE_BITREV_EN is defined.
module omsp_permute
    import omsp_permute_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h0190,
    parameter int          DIM_LOG2  = 2
) (
    input  logic          mclk,
    input  logic          puc_rst,
    omsp_permute_if.slave bus,
    output logic          irq_perm
);
    localparam int              AW       = 2 * DIM_LOG2;
    localparam int              DEPTH    = 1 << AW;
    localparam logic [AW-1:0]   LAST_IDX = {AW{1'b1}};
    localparam logic [AW-1:0]   ONE_IDX  = {{(AW-1){1'b0}}, 1'b1};

    perm_state_e   state_r, state_nxt_s;
    perm_mode_e    mode_r, busy_mode_r;
    logic          ie_r, done_r, ovf_r;
    logic [AW-1:0] wp_r, rp_r, k_r, src_s;
    logic [15:0]   in_buf_r  [DEPTH];
    logic [15:0]   out_buf_r [DEPTH];

    logic          sel_s, rd_s, ctrl_wr_s, stat_wr_s, din_wr_s, dout_rd_s;
    logic          start_s, clr_s, start_ok_s;
    logic          load_we_s, ovf_set_s, copy_en_s, rp_adv_s, done_set_s, drain_end_s;
    logic [1:0]    ofs_s;
    logic [15:0]   rdata_s;

    assign sel_s     = bus.per_en & (bus.per_addr[13:2] == BASE_ADDR[14:3]);
    assign ofs_s     = bus.per_addr[1:0];
    assign rd_s      = sel_s & (bus.per_we == 2'b00);
    assign ctrl_wr_s = sel_s & (ofs_s == OFS_CTRL) & bus.per_we[0];
    assign stat_wr_s = sel_s & (ofs_s == OFS_STAT) & bus.per_we[0];
    assign din_wr_s  = sel_s & (ofs_s == OFS_DIN) & (bus.per_we == 2'b11);
    assign dout_rd_s = rd_s & (ofs_s == OFS_DOUT);
    assign start_s   = ctrl_wr_s & bus.per_din[CTRL_START];
    assign clr_s     = ctrl_wr_s & bus.per_din[CTRL_CLR];

    omsp_permute_index #(.DIM_LOG2(DIM_LOG2)) u_index (
        .mode (busy_mode_r),
        .k    (k_r),
        .src  (src_s)
    );

    // State register
    always_ff @(posedge mclk) begin
        if (puc_rst) state_r <= ST_LOAD;
        else         state_r <= state_nxt_s;
    end

    // Next-state logic; CLR overrides every transition, including a simultaneous START
    always_comb begin
        state_nxt_s = state_r;
        if (clr_s) begin
            state_nxt_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_LOAD:  if (din_wr_s && (wp_r == LAST_IDX))  state_nxt_s = ST_FULL;  else state_nxt_s = ST_LOAD;
                ST_FULL:  if (start_s)                         state_nxt_s = ST_BUSY;  else state_nxt_s = ST_FULL;
                ST_BUSY:  if (k_r == LAST_IDX)                 state_nxt_s = ST_DRAIN; else state_nxt_s = ST_BUSY;
                ST_DRAIN: if (dout_rd_s && (rp_r == LAST_IDX)) state_nxt_s = ST_LOAD;  else state_nxt_s = ST_DRAIN;
                default:  state_nxt_s = ST_LOAD;
            endcase
        end
    end

    // Output logic: datapath strobes and the read-data mux
    always_comb begin
        load_we_s   = din_wr_s & (state_r == ST_LOAD);
        ovf_set_s   = din_wr_s & (state_r != ST_LOAD);
        copy_en_s   = (state_r == ST_BUSY);
        done_set_s  = copy_en_s & (k_r == LAST_IDX);
        rp_adv_s    = dout_rd_s & (state_r == ST_DRAIN);
        drain_end_s = rp_adv_s & (rp_r == LAST_IDX);
        start_ok_s  = start_s & ~clr_s & (state_r == ST_FULL);
        rdata_s     = 16'h0000;
        if (rd_s) begin
            case (ofs_s)
                OFS_CTRL: begin
                    rdata_s[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_r;
                    rdata_s[CTRL_IE]                     = ie_r;
                end
                OFS_STAT: begin
                    rdata_s[STAT_FULL]  = (state_r == ST_FULL);
                    rdata_s[STAT_BUSY]  = (state_r == ST_BUSY);
                    rdata_s[STAT_DONE]  = done_r;
                    rdata_s[STAT_DRAIN] = (state_r == ST_DRAIN);
                    rdata_s[STAT_OVF]   = ovf_r;
                    rdata_s[STAT_CAP]   = BITREV_CAP;
                end
                OFS_DOUT: begin
                    if (state_r == ST_DRAIN) rdata_s = out_buf_r[rp_r];
                    else                     rdata_s = 16'h0000;
                end
                default: rdata_s = 16'h0000;
            endcase
        end else begin
            rdata_s = 16'h0000;
        end
    end

    assign bus.per_dout = rdata_s;
    assign irq_perm     = done_r & ie_r;

    // Control registers and pointers; the set of DONE takes priority over its W1C
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            mode_r      <= MODE_IDENT;
            busy_mode_r <= MODE_IDENT;
            ie_r        <= 1'b0;
            done_r      <= 1'b0;
            ovf_r       <= 1'b0;
            wp_r        <= '0;
            rp_r        <= '0;
            k_r         <= '0;
        end else begin
            if (ctrl_wr_s) begin
                mode_r <= perm_mode_e'(bus.per_din[CTRL_MODE_MSB:CTRL_MODE_LSB]);
                ie_r   <= bus.per_din[CTRL_IE];
            end
            if (start_ok_s) busy_mode_r <= perm_mode_e'(bus.per_din[CTRL_MODE_MSB:CTRL_MODE_LSB]);

            if (clr_s)          wp_r <= '0;
            else if (load_we_s) wp_r <= wp_r + ONE_IDX;

            if (clr_s)         rp_r <= '0;
            else if (rp_adv_s) rp_r <= rp_r + ONE_IDX;

            if (clr_s || start_ok_s) k_r <= '0;
            else if (copy_en_s)      k_r <= k_r + ONE_IDX;

            if (clr_s)                                 done_r <= 1'b0;
            else if (done_set_s)                       done_r <= 1'b1;
            else if (drain_end_s)                      done_r <= 1'b0;
            else if (stat_wr_s && bus.per_din[STAT_DONE]) done_r <= 1'b0;

            if (ovf_set_s)                                ovf_r <= 1'b1;
            else if (stat_wr_s && bus.per_din[STAT_OVF]) ovf_r <= 1'b0;
        end
    end

    // Word buffers carry no reset
    always_ff @(posedge mclk) begin
        if (load_we_s) in_buf_r[wp_r]  <= bus.per_din;
        if (copy_en_s) out_buf_r[k_r]  <= in_buf_r[src_s];
    end
endmodule

// File: tb/tb_omsp_permute.sv
// Randomised self-checking bench for omsp_permute: two instances (4x4 and 8x8) on one driven bus.
`timescale 1ns/1ps
module tb_omsp_permute;
    localparam logic [14:0] BASE_A = 15'h0190;
    localparam logic [14:0] BASE_B = 15'h01A0;
`ifdef PERMUTE_BITREV_EN
    localparam logic [15:0] CAP = 16'h8000;
    localparam bit BITREV = 1'b1;
`else
    localparam logic [15:0] CAP = 16'h0000;
    localparam bit BITREV = 1'b0;
`endif

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic [13:0] addr = 14'h0000;
    logic [15:0] din = 16'h0000;
    logic        en = 1'b0;
    logic [1:0]  we = 2'b00;
    logic        irq_a, irq_b;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] data_q[$];
    logic [15:0] out_q[$];

    omsp_permute_if if_a ();
    omsp_permute_if if_b ();
    assign if_a.per_addr = addr; assign if_a.per_din = din; assign if_a.per_en = en; assign if_a.per_we = we;
    assign if_b.per_addr = addr; assign if_b.per_din = din; assign if_b.per_en = en; assign if_b.per_we = we;

    omsp_permute #(.BASE_ADDR(BASE_A), .DIM_LOG2(2)) dut_a (.mclk(mclk), .puc_rst(puc_rst), .bus(if_a), .irq_perm(irq_a));
    omsp_permute #(.BASE_ADDR(BASE_B), .DIM_LOG2(3)) dut_b (.mclk(mclk), .puc_rst(puc_rst), .bus(if_b), .irq_perm(irq_b));

    always #5 mclk = ~mclk;

    // Reference index map computed with plain arithmetic on row/column numbers
    function automatic int src_idx(input int mode, input int kk, input int k);
        int hi, lo, r;
        hi = k / (1 << kk);
        lo = k % (1 << kk);
        r  = 0;
        if (mode == 1) return lo * (1 << kk) + hi;
        if (mode == 2 && BITREV) begin
            for (int i = 0; i < 2 * kk; i++) if (((k >> i) & 1) == 1) r += 1 << (2 * kk - 1 - i);
            return r;
        end
        return k;
    endfunction

    task automatic wr(input int d, input logic [1:0] ofs, input logic [15:0] data, input logic [1:0] be);
        addr = ((d == 0) ? BASE_A[14:1] : BASE_B[14:1]) + 14'(ofs);
        din = data; we = be; en = 1'b1;
        @(posedge mclk); #1;
        en = 1'b0; we = 2'b00;
    endtask

    task automatic rd(input int d, input logic [1:0] ofs, output logic [15:0] data);
        addr = ((d == 0) ? BASE_A[14:1] : BASE_B[14:1]) + 14'(ofs);
        we = 2'b00; en = 1'b1; #1;
        data = if_a.per_dout | if_b.per_dout;
        @(posedge mclk); #1;
        en = 1'b0;
    endtask

    task automatic load(input int d, input int n, input bit seq);
        logic [15:0] v;
        data_q.delete();
        for (int i = 0; i < n; i++) begin
            v = seq ? 16'(i) : 16'($urandom_range(0, 32'hBEEE));
            data_q.push_back(v);
            wr(d, 2'd2, v, 2'b11);
        end
    endtask

    task automatic drain(input int d);
        logic [15:0] v;
        out_q.delete();
        for (int i = 0; i < ((d == 0) ? 16 : 64); i++) begin
            rd(d, 2'd3, v);
            out_q.push_back(v);
        end
    endtask

    task automatic wait_done(input int d, input int budget, output logic [15:0] s);
        int n = 0;
        do begin rd(d, 2'd1, s); n++; end while (!s[2] && n < budget);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        puc_rst = 1'b1; repeat (2) @(posedge mclk); #1; puc_rst = 1'b0;
        checks++; if (if_a.per_dout !== 16'h0000 || irq_a !== 1'b0 || irq_b !== 1'b0) begin errors++; $display("FAIL reset_idle: dout %h irq %b%b expected 0000 00", if_a.per_dout, irq_a, irq_b); end
        rd(0, 2'd1, v); checks++; if (v !== CAP) begin errors++; $display("FAIL reset_stat: got %h expected %h", v, CAP); end
        rd(0, 2'd0, v); checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_ctrl: got %h expected 0000", v); end
        rd(0, 2'd3, v); checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h expected 0000", v); end
        rd(1, 2'd1, v); checks++; if (v !== CAP) begin errors++; $display("FAIL reset_stat_b: got %h expected %h", v, CAP); end
    endtask

    task automatic test_transpose();
        logic [15:0] v;
        load(0, 16, 1'b1);
        wr(0, 2'd0, 16'h0005, 2'b01);
        repeat (15) @(posedge mclk); #1;
        rd(0, 2'd1, v); checks++; if (v !== (CAP | 16'h0002)) begin errors++; $display("FAIL trans_busy: got %h expected %h", v, CAP | 16'h0002); end
        rd(0, 2'd1, v); checks++; if (v !== (CAP | 16'h000C)) begin errors++; $display("FAIL trans_done: got %h expected %h", v, CAP | 16'h000C); end
        drain(0);
        for (int k = 0; k < 16; k++) begin
            checks++; if (out_q[k] !== data_q[src_idx(1, 2, k)]) begin errors++; $display("FAIL trans_dout[%0d]: got %h expected %h", k, out_q[k], data_q[src_idx(1, 2, k)]); end
        end
        rd(0, 2'd1, v); checks++; if (v !== CAP) begin errors++; $display("FAIL trans_after: got %h expected %h", v, CAP); end
    endtask

    task automatic test_bitrev();
        logic [15:0] v;
        load(0, 16, 1'b1);
        wr(0, 2'd0, 16'h0006, 2'b01);
        wait_done(0, 40, v);
        checks++; if (v !== (CAP | 16'h000C)) begin errors++; $display("FAIL bitrev_done: got %h expected %h", v, CAP | 16'h000C); end
        drain(0);
        for (int k = 0; k < 16; k++) begin
            checks++; if (out_q[k] !== data_q[src_idx(2, 2, k)]) begin errors++; $display("FAIL bitrev_dout[%0d]: got %h expected %h", k, out_q[k], data_q[src_idx(2, 2, k)]); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] v;
        load(0, 16, 1'b0);
        wr(0, 2'd2, 16'hBEEF, 2'b11);
        rd(0, 2'd1, v); checks++; if (v !== (CAP | 16'h0011)) begin errors++; $display("FAIL ovf_set: got %h expected %h", v, CAP | 16'h0011); end
        wr(0, 2'd0, 16'h0004, 2'b01);
        wait_done(0, 40, v);
        drain(0);
        for (int k = 0; k < 16; k++) begin
            checks++; if (out_q[k] !== data_q[k]) begin errors++; $display("FAIL ovf_dout[%0d]: got %h expected %h", k, out_q[k], data_q[k]); end
        end
        rd(0, 2'd1, v); checks++; if (v !== (CAP | 16'h0010)) begin errors++; $display("FAIL ovf_kept: got %h expected %h", v, CAP | 16'h0010); end
        wr(0, 2'd1, 16'h0010, 2'b01);
        rd(0, 2'd1, v); checks++; if (v !== CAP) begin errors++; $display("FAIL ovf_w1c: got %h expected %h", v, CAP); end
    endtask

    task automatic test_partial_start();
        logic [15:0] v;
        int busy_seen = 0;
        logic [15:0] first_q[$];
        load(0, 10, 1'b0);
        first_q = data_q;
        wr(0, 2'd0, 16'h0004, 2'b01);
        for (int i = 0; i < 20; i++) begin rd(0, 2'd1, v); if (v[1]) busy_seen++; end
        checks++; if (busy_seen !== 0 || v !== CAP) begin errors++; $display("FAIL early_start: busy cycles %0d stat %h expected 0 and %h", busy_seen, v, CAP); end
        rd(0, 2'd3, v); checks++; if (v !== 16'h0000) begin errors++; $display("FAIL dout_in_load: got %h expected 0000", v); end
        wr(0, 2'd2, 16'h1234, 2'b10);
        load(0, 5, 1'b0);
        rd(0, 2'd1, v); checks++; if (v !== CAP) begin errors++; $display("FAIL not_full_yet: got %h expected %h", v, CAP); end
        first_q = {first_q, data_q};
        load(0, 1, 1'b0);
        first_q = {first_q, data_q};
        data_q = first_q;
        rd(0, 2'd1, v); checks++; if (v !== (CAP | 16'h0001)) begin errors++; $display("FAIL full_after16: got %h expected %h", v, CAP | 16'h0001); end
        wr(0, 2'd0, 16'h0004, 2'b01);
        wait_done(0, 40, v);
        drain(0);
        for (int k = 0; k < 16; k++) begin
            checks++; if (out_q[k] !== data_q[k]) begin errors++; $display("FAIL partial_dout[%0d]: got %h expected %h", k, out_q[k], data_q[k]); end
        end
    endtask

    task automatic test_irq();
        logic [15:0] v;
        load(0, 16, 1'b0);
        wr(0, 2'd0, 16'h000D, 2'b01);
        repeat (15) @(posedge mclk); #1;
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq_a); end
        @(posedge mclk); #1;
        checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", irq_a); end
        wr(0, 2'd2, 16'h5555, 2'b11);
        wr(0, 2'd1, 16'h0004, 2'b01);
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b expected 0", irq_a); end
        rd(0, 2'd1, v); checks++; if (v !== (CAP | 16'h0018)) begin errors++; $display("FAIL drain_ovf: got %h expected %h", v, CAP | 16'h0018); end
        wr(0, 2'd1, 16'h0010, 2'b01);
        drain(0);
        for (int k = 0; k < 16; k++) begin
            checks++; if (out_q[k] !== data_q[src_idx(1, 2, k)]) begin errors++; $display("FAIL irq_dout[%0d]: got %h expected %h", k, out_q[k], data_q[src_idx(1, 2, k)]); end
        end
        wr(0, 2'd0, 16'h0000, 2'b01);
    endtask

    task automatic test_mode_latch();
        logic [15:0] v;
        load(0, 16, 1'b0);
        wr(0, 2'd0, 16'h0005, 2'b01);
        wr(0, 2'd0, 16'h0000, 2'b01);
        rd(0, 2'd0, v); checks++; if (v !== 16'h0000) begin errors++; $display("FAIL mode_readback: got %h expected 0000", v); end
        wait_done(0, 40, v);
        drain(0);
        for (int k = 0; k < 16; k++) begin
            checks++; if (out_q[k] !== data_q[src_idx(1, 2, k)]) begin errors++; $display("FAIL latch_dout[%0d]: got %h expected %h", k, out_q[k], data_q[src_idx(1, 2, k)]); end
        end
    endtask

    task automatic test_start_clr();
        logic [15:0] v;
        load(0, 16, 1'b0);
        wr(0, 2'd0, 16'h0014, 2'b01);
        rd(0, 2'd1, v); checks++; if (v !== CAP) begin errors++; $display("FAIL clr_wins: got %h expected %h", v, CAP); end
        rd(0, 2'd1, v); checks++; if (v !== CAP) begin errors++; $display("FAIL clr_stays: got %h expected %h", v, CAP); end
    endtask

    task automatic test_reset_mid_busy();
        logic [15:0] v;
        load(0, 16, 1'b1);
        wr(0, 2'd0, 16'h000D, 2'b01);
        repeat (7) @(posedge mclk); #1;
        puc_rst = 1'b1; @(posedge mclk); #1; puc_rst = 1'b0;
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq_a); end
        rd(0, 2'd1, v); checks++; if (v !== CAP) begin errors++; $display("FAIL rst_stat: got %h expected %h", v, CAP); end
        load(0, 16, 1'b1);
        wr(0, 2'd0, 16'h0004, 2'b01);
        wait_done(0, 40, v);
        checks++; if (v !== (CAP | 16'h000C)) begin errors++; $display("FAIL rst_reload: got %h expected %h", v, CAP | 16'h000C); end
        drain(0);
        for (int k = 0; k < 16; k++) begin
            checks++; if (out_q[k] !== 16'(k)) begin errors++; $display("FAIL rst_dout[%0d]: got %h expected %h", k, out_q[k], 16'(k)); end
        end
    endtask

    task automatic test_dim3();
        logic [15:0] v;
        load(1, 64, 1'b0);
        wr(1, 2'd0, 16'h0005, 2'b01);
        wait_done(1, 100, v);
        checks++; if (v !== (CAP | 16'h000C)) begin errors++; $display("FAIL dim3_done: got %h expected %h", v, CAP | 16'h000C); end
        drain(1);
        for (int k = 0; k < 64; k++) begin
            checks++; if (out_q[k] !== data_q[src_idx(1, 3, k)]) begin errors++; $display("FAIL dim3_dout[%0d]: got %h expected %h", k, out_q[k], data_q[src_idx(1, 3, k)]); end
        end
        rd(1, 2'd1, v); checks++; if (v !== CAP) begin errors++; $display("FAIL dim3_after: got %h expected %h", v, CAP); end
    endtask

    initial begin
        test_reset();
        test_transpose();
        test_bitrev();
        test_overflow();
        test_partial_start();
        test_irq();
        test_mode_latch();
        test_start_clr();
        test_reset_mid_busy();
        test_dim3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/omsp_permute.md
Name: omsp_permute

Overview:
Parametrised memory-mapped permutation peripheral on the openMSP430 peripheral bus; next generation of the fixed 4x4 transpose block. The CPU streams 2^(2*DIM_LOG2) words in, selects a mode (identity / transpose / bit-reverse), starts a copy phase, then streams permuted words out. It serves FFT input reordering and matrix transposes of any power-of-two size and raises an optional completion interrupt.

Parameters:
BASE_ADDR, 15'h0190, byte base address; the block decodes 4 words (8 bytes), aligned.
DIM_LOG2, 2, log2 of matrix side; DEPTH = 2^(2*DIM_LOG2) words (default 16); legal range 1..4.

Ports:
mclk  in  1  system clock; all state updates on its rising edge
puc_rst  in  1  synchronous active-high reset
per_addr  in  14  peripheral word address
per_din  in  16  write data
per_en  in  1  peripheral access strobe
per_we  in  2  byte write enables; 00 = read
per_dout  out  16  read data; 0 when not selected
irq_perm  out  1  level interrupt = DONE & IE

Behaviour:
- Select: per_en & (per_addr[13:2] == BASE_ADDR[14:3]). Word offsets: 0 CTRL, 1 STAT, 2 DIN, 3 DOUT.
- CTRL (RW; bits written when per_we[0]=1): [1:0] MODE (0 identity, 1 transpose, 2 bit-reverse, 3 = identity); [2] START (write-1 pulse, reads 0); [3] IE; [4] CLR (write-1 pulse, reads 0).
- STAT (R): [0] FULL, [1] BUSY, [2] DONE, [3] DRAIN, [4] OVF. Writing 1 to bit 2 or bit 4 clears DONE or OVF respectively.
- DIN: write with per_we==2'b11 stores in_buf[wp], wp++. Byte writes are ignored and do not advance wp.
- DOUT read: returns out_buf[rp] combinationally; rp++ on the same edge.
- Reset values: per_dout=0, irq_perm=0, MODE=0, IE=0, wp=rp=0, state LOAD, DONE=OVF=0. Buffers are not reset.
- States:
  - LOAD: accepts DIN. When wp reaches DEPTH, go to FULL.
  - FULL: START -> BUSY with k=0. A DIN write here sets OVF and the data is dropped.
  - BUSY: each cycle out_buf[k] <= in_buf[f(k)], k++. When k = DEPTH-1 is written, go to DRAIN and set DONE. BUSY lasts exactly DEPTH cycles after the START edge.
  - DRAIN: each DOUT read advances rp. The read of rp = DEPTH-1 returns to LOAD with wp=rp=0.
- Index maps for j = {hi[K-1:0], lo[K-1:0]}, K = DIM_LOG2: identity f(j)=j; transpose f(j)={lo,hi}; bit-reverse f(j)=bitrev_{2K}(j).
- Boundaries:
  - START outside FULL is ignored.
  - DIN write in BUSY or DRAIN sets OVF and is dropped.
  - DOUT read outside DRAIN returns 0 and does not move rp.
  - MODE write during BUSY is latched but takes effect only at the next START; the mode is sampled on the START edge.
  - CLR in any state -> LOAD, wp=rp=k=0, DONE=0. OVF is preserved.
  - START and CLR in the same write: CLR wins.
  - puc_rst mid-BUSY aborts the copy; out_buf contents are then undefined.
  - A DONE W1C on the same edge that sets DONE leaves DONE=1.

Optional Feature:
- Macro: PERMUTE_BITREV_EN.
- Defined: MODE 2 performs bit-reverse as specified.
- Undefined: MODE 2 behaves as identity, the bit-reverse index logic is not synthesised, and STAT[15] reads 0 (reads 1 when defined, as a capability flag).

Decomposition:
- Include file omsp_permute_defines.v: register offsets, CTRL/STAT bit positions, MODE encodings, state encodings (LOAD=0, FULL=1, BUSY=2, DRAIN=3).
- One sub-module, omsp_permute_index: combinational mapping (mode, k) -> source index, parametrised by DIM_LOG2.

Test Plan:
- DIM_LOG2=2, MODE=1: DIN writes 0..15, START, wait 16 cycles -> STAT=0x000C; 16 DOUT reads = 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; then STAT=0.
- MODE=2 with PERMUTE_BITREV_EN: load 0..15, START -> reads 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. Without the macro -> reads 0..15.
- Load 16 words, write a 17th (0xBEEF) -> OVF=1; output does not contain 0xBEEF. W1C of bit 4 -> OVF=0.
- Load 10 words, START -> state stays LOAD, BUSY never asserts; 6 more writes -> FULL=1.
- IE=1, load, START -> irq_perm rises exactly 16 cycles after the START edge; W1C DONE -> irq_perm=0 the next cycle.
- puc_rst pulsed mid-BUSY (k=7) -> STAT=0, irq_perm=0, wp=0. Reload 0..15 with MODE=0 -> reads 0..15. DIM_LOG2=3 transpose of 64 words also checked.
